// File: rtl/e_rr_arb_1hot.sv
// Round-robin arbiter with a registered one-hot grant held until acknowledged.
// Optional macro E_RR_ARB_1HOT_LOCK_EN adds i_lock to keep a grant across acked beats.
module e_rr_arb_1hot #(
    parameter  int W  = 4,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_req,
    input  logic          i_ack,
`ifdef E_RR_ARB_1HOT_LOCK_EN
    input  logic          i_lock,
`endif
    output logic [W-1:0]  o_gnt,
    output logic          o_gnt_vld,
    output logic [IW-1:0] o_gnt_idx
);

    localparam logic [0:0]    STATE_IDLE  = 1'b0;
    localparam logic [0:0]    STATE_GRANT = 1'b1;
    localparam logic [IW-1:0] PTR_MAX     = IW'(W - 1);
    localparam logic [IW:0]   W_EXT       = (IW + 1)'(W);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  gnt_q, gnt_d;
    logic          vld_q, vld_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          lock_w;
    logic [W-1:0]  req_rot;
    logic          win_found;
    logic [IW-1:0] win_off;
    logic [IW:0]   win_sum;
    logic [IW-1:0] win_idx;

`ifdef E_RR_ARB_1HOT_LOCK_EN
    assign lock_w = i_lock;
`else
    assign lock_w = 1'b0;
`endif

    // Rotate the doubled request vector so bit 0 is the requestor at ptr,
    // then map the first set offset back to an absolute index.
    always_comb begin
        req_rot   = W'({i_req, i_req} >> ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int j = 0; j < W; j++) begin
            if (!win_found && req_rot[j]) begin
                win_found = 1'b1;
                win_off   = IW'(j);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        win_idx = (win_sum >= W_EXT) ? IW'(win_sum - W_EXT) : win_sum[IW-1:0];
    end

    // NOTE: every *_d starts from its held value so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        case (state_q)
            STATE_IDLE: begin
                if (win_found) begin
                    for (int i = 0; i < W; i++) begin
                        gnt_d[i] = (win_idx == IW'(i));
                    end
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    state_d = STATE_GRANT;
                end
            end
            STATE_GRANT: begin
                // A locked ack closes one beat only; the grant and ptr stay put.
                if (i_ack && !lock_w) begin
                    ptr_d   = (idx_q == PTR_MAX) ? '0 : idx_q + 1'b1;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    idx_d   = '0;
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every register samples
    // pre-edge values; the synchronous reset clears all state, outputs included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_vld = vld_q;
    assign o_gnt_idx = idx_q;

endmodule

// File: tb/tb_e_rr_arb_1hot.sv
// Self-checking bench for e_rr_arb_1hot: directed scenarios plus random traffic
// compared every cycle against a queue-free behavioural round-robin model.
module tb_e_rr_arb_1hot;

    localparam int W  = 4;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  i_req;
    logic          i_ack;
    logic          i_lock;
    logic [W-1:0]  o_gnt;
    logic          o_gnt_vld;
    logic [IW-1:0] o_gnt_idx;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a busy flag, the granted requestor and the pointer.
    bit m_busy = 1'b0;
    int m_k    = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    e_rr_arb_1hot #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_ack     (i_ack),
`ifdef E_RR_ARB_1HOT_LOCK_EN
        .i_lock    (i_lock),
`endif
        .o_gnt     (o_gnt),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt_idx (o_gnt_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit lock_eff;
        bit found;
        int c;
`ifdef E_RR_ARB_1HOT_LOCK_EN
        lock_eff = i_lock;
`else
        lock_eff = 1'b0;
`endif
        if (rst) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int j = 0; j < W; j++) begin
                c = (m_ptr + j) % W;
                if (!found && i_req[c]) begin
                    found = 1'b1;
                    m_k  <= c;
                end
            end
            m_busy <= found;
        end else if (i_ack && !lock_eff) begin
            m_ptr  <= (m_k + 1) % W;
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        logic [W-1:0] exp_gnt;
        if (chk_en) begin
            exp_gnt = m_busy ? (W'(1) << m_k) : '0;
            check("model_gnt", 32'(o_gnt), 32'(exp_gnt));
            check("model_vld", 32'(o_gnt_vld), 32'(m_busy));
            check("model_idx", 32'(o_gnt_idx), m_busy ? 32'(m_k) : 32'd0);
            check("onehot_inv", 32'($onehot0(o_gnt) && ((o_gnt != '0) == o_gnt_vld)), 32'd1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic exp_out(input string name, input logic [W-1:0] g, input logic v, input logic [IW-1:0] k);
        check({name, "_gnt"}, 32'(o_gnt), 32'(g));
        check({name, "_vld"}, 32'(o_gnt_vld), 32'(v));
        check({name, "_idx"}, 32'(o_gnt_idx), 32'(k));
    endtask

    initial begin
        logic [W-1:0] fair_seq [5];
        fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; i_req = '0; i_ack = 1'b0; i_lock = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        exp_out("reset", '0, 1'b0, '0);

        rst = 1'b0;
        repeat (5) begin
            tick();
            exp_out("idle_noreq", '0, 1'b0, '0);
        end

        // Ack in IDLE must do nothing.
        i_ack = 1'b1; tick(); exp_out("ack_in_idle", '0, 1'b0, '0); i_ack = 1'b0;

        i_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_out("rr_fair", fair_seq[i], 1'b1, IW'(i % W));
            i_ack = 1'b1;
            tick();
            exp_out("rr_bubble", '0, 1'b0, '0);
            i_ack = 1'b0;
        end
        check("model_ptr_after_fair", 32'(m_ptr), 32'd1);

        repeat (2) begin
            tick(); i_ack = 1'b1; tick(); i_ack = 1'b0;
        end
        check("model_ptr_3", 32'(m_ptr), 32'd3);

        i_req = 4'b0011;
        tick(); exp_out("wrap_search", 4'b0001, 1'b1, 2'd0);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        tick(); exp_out("after_wrap", 4'b0010, 1'b1, 2'd1);
        i_ack = 1'b1; tick(); i_ack = 1'b0;

        i_req = 4'b0100;
        tick(); exp_out("sticky_start", 4'b0100, 1'b1, 2'd2);
        i_req = 4'b0001;
        repeat (3) begin
            tick(); exp_out("sticky_hold", 4'b0100, 1'b1, 2'd2);
        end
        i_ack = 1'b1; tick(); exp_out("sticky_release", '0, 1'b0, '0);
        i_ack = 1'b0; tick(); exp_out("sticky_next", 4'b0001, 1'b1, 2'd0);
        i_ack = 1'b1; tick(); i_ack = 1'b0;

        i_req = 4'b1000;
        tick(); exp_out("pre_rst_grant", 4'b1000, 1'b1, 2'd3);
        rst = 1'b1; i_req = 4'b1111;
        tick(); exp_out("rst_mid_grant", '0, 1'b0, '0);
        rst = 1'b0;
        tick(); exp_out("post_rst_grant", 4'b0001, 1'b1, 2'd0);
        i_ack = 1'b1; tick(); i_ack = 1'b0;

`ifdef E_RR_ARB_1HOT_LOCK_EN
        i_req = 4'b0010;
        tick(); exp_out("lock_grant", 4'b0010, 1'b1, 2'd1);
        i_req = 4'b1111; i_ack = 1'b1; i_lock = 1'b1;
        repeat (3) begin
            tick(); exp_out("lock_hold", 4'b0010, 1'b1, 2'd1);
        end
        i_lock = 1'b0;
        tick(); exp_out("lock_release", '0, 1'b0, '0);
        i_ack = 1'b0;
        tick(); exp_out("lock_next", 4'b0100, 1'b1, 2'd2);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
`endif

        repeat (3000) begin
            i_req  = W'($urandom);
            i_ack  = 1'($urandom_range(0, 1));
            i_lock = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 96) == 0);
            tick();
        end

        rst = 1'b0; i_ack = 1'b0; i_req = '0;
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
